dmem_store_buffer: RTL
======================

# dmem_store_buffer

Posted-write store buffer between the pipelined core's data-memory port (MEM stage) and a backing data memory that accepts writes through a request/acknowledge handshake. Core stores are queued in a small FIFO and drained to memory in order. Core loads read the backing memory combinationally, with store-to-load forwarding from the youngest matching buffered entry, so the core keeps its single-cycle load timing.

## Interface

- `DEPTH`, default 4: number of buffer entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `core_we`  in  1  core store strobe (MEM stage `dmem_write`).
- `core_addr`  in  32  core byte address (MEM stage ALU result); used for both stores and loads.
- `core_wdata`  in  32  core store data.
- `core_rdata`  out  32  load data returned to core; combinational.
- `buf_full`  out  1  count == DEPTH; intended as a stall source for the hazard unit.
- `buf_empty`  out  1  count == 0.
- `overflow`  out  1  sticky; a store was presented while full and was dropped.
- `mem_wreq`  out  1  write request to backing memory.
- `mem_waddr`  out  32  head-entry address.
- `mem_wdata`  out  32  head-entry data.
- `mem_wack`  in  1  memory accepted the write on this rising edge.
- `mem_raddr`  out  32  read address to backing memory; equals `core_addr`.
- `mem_rdata`  in  32  combinational read data from backing memory.

## Operation

- **Storage:** circular FIFO of DEPTH entries {addr[31:0], data[31:0]}. State is a head pointer, a tail pointer (log2 DEPTH bits each, wrapping modulo DEPTH) and a count (log2 DEPTH + 1 bits, range 0..DEPTH).
- **Enqueue:** occurs when `core_we` is 1 and `buf_full` is 0. The entry is written at tail, tail increments, and count increments.
- **Store while full:**
  - A store with `core_we` = 1 and `buf_full` = 1 is dropped and `overflow` is set.
  - `overflow` clears only on reset.
  - The full check uses the registered count, so a dequeue in the same cycle does not admit the store.
- **Dequeue:**
  - `mem_wreq` = !`buf_empty`, and `mem_waddr`/`mem_wdata` come from the head entry.
  - When `mem_wreq` and `mem_wack` are both 1 at a rising edge, head increments and count decrements.
  - `mem_wack` while `mem_wreq` = 0 is ignored.
- **Simultaneous enqueue and dequeue** (not full, not empty): both pointers advance and count is unchanged.
- **Handshake:** once raised, `mem_wreq` stays high and `mem_waddr`/`mem_wdata` stay stable until the edge that samples `mem_wack` = 1. Drains are strictly in program order.
- **Load forwarding:**
  - Compare `core_addr`[31:2] against the addr[31:2] of every valid entry. Valid means the entry lies within count positions of head.
  - On any match, `core_rdata` = data of the youngest matching entry (closest to tail). Otherwise `core_rdata` = `mem_rdata`.
  - Forwarding applies whenever `core_we` = 0. When `core_we` = 1, `core_rdata` is don't-care.
  - The head entry being acknowledged this cycle still forwards; the memory holds it from the next cycle on.
- **Addressing and access width:**
  - Word accesses only; there are no byte enables.
  - `core_addr`[1:0] is passed unchanged into the entry and onto `mem_waddr`, but is ignored for matching.
- **Reset:** see Timing.

## Timing

- Store to `mem_wreq`:
  - A store enqueued at edge N makes `mem_wreq` high after edge N, with no same-cycle bypass to memory.
  - With `mem_wack` tied to 1, that store is written at edge N+1.
- Sustained drain rate is one entry per cycle while `mem_wack` is held high.
- Flags after an edge:
  - `buf_full` and `buf_empty` are functions of the registered count and are valid immediately after the edge.
  - Enqueue into an empty buffer: `buf_empty` falls after that edge.
  - Dequeue of the last entry: `buf_empty` rises after that edge.
- `core_rdata` and `mem_raddr` are purely combinational from `core_addr`, buffer state and `mem_rdata`, with zero latency.
- **Reset values:**
  - Pointers and count are 0.
  - All entry storage is 0.
  - `buf_empty` = 1, `buf_full` = 0, `overflow` = 0, `mem_wreq` = 0.
  - `mem_waddr` = 0 and `mem_wdata` = 0.
- **Reset asserted mid-drain:** all pending entries are discarded and `mem_wreq` drops immediately (asynchronously). After release, no write is re-issued.

## Test plan

- **Single store, then drain:**
  - Stimulus: reset, then `core_we` = 1 with addr 0x10, data 0xAAAA0001 for one cycle; `mem_wack` = 0 for 3 cycles, then 1.
  - Required: `mem_wreq` is high with 0x10/0xAAAA0001 stable for 4 cycles; after the ack edge, `buf_empty` = 1 and `mem_wreq` = 0.
- **Fill and overflow (DEPTH = 4, `mem_wack` = 0):**
  - Stimulus: 5 consecutive stores to 0x0, 0x4, 0x8, 0xC, 0x10.
  - Required: `buf_full` = 1 after the 4th store; the 5th store is dropped and `overflow` = 1; the drain order is 0x0, 0x4, 0x8, 0xC.
- **Youngest-match forwarding:**
  - Stimulus: stores 0x20←1, then 0x24←2, then 0x20←3, with `mem_wack` = 0; then a load from 0x22.
  - Required: `core_rdata` = 3. A load from 0x30 with `mem_rdata` = 0xDEAD returns 0xDEAD.
- **Simultaneous enqueue and dequeue, with wrap:**
  - Stimulus: `mem_wack` = 1 and one store per cycle for 10 cycles.
  - Required: count stays 1, pointers wrap past DEPTH−1, and all 10 writes reach memory in order.
- **Forwarding of an acked entry:**
  - Stimulus: one entry 0x40←7 in the buffer; load 0x40 in the same cycle as `mem_wack` = 1.
  - Required: `core_rdata` = 7 that cycle; on the next cycle, with the memory model updated, `core_rdata` = 7 from `mem_rdata`.
- **Reset mid-operation:**
  - Stimulus: 3 entries queued; pulse `reset_n` low between edges.
  - Required: `mem_wreq` falls immediately, `buf_empty` = 1 and `overflow` = 0; no writes issue after release.

Source files
------------

// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module  : dmem_store_buffer
// Purpose : Posted-write FIFO between core MEM stage and data memory, with
//           youngest-entry store-to-load forwarding.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        buf_full,
  output logic        buf_empty,
  output logic        overflow,
  output logic        mem_wreq,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic        mem_wack,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);

  logic [31:0]        r_addr [DEPTH];
  logic [31:0]        r_data [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;

  logic               w_enq;
  logic               w_deq;
  logic               w_fwd_hit;
  logic [31:0]        w_fwd_data;
  logic [c_PTR_W-1:0] w_idx;

  assign buf_full  = (r_count == c_FULL);
  assign buf_empty = (r_count == '0);
  assign overflow  = r_overflow;
  assign mem_wreq  = !buf_empty;
  assign mem_waddr = r_addr[r_head];
  assign mem_wdata = r_data[r_head];
  assign mem_raddr = core_addr;

  // Full check uses the registered count: a same-cycle drain never admits a store.
  assign w_enq = core_we && !buf_full;
  assign w_deq = mem_wreq && mem_wack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_tail] <= core_addr;
        r_data[r_tail] <= core_wdata;
        r_tail         <= r_tail + c_PTR_ONE;
      end
      if (w_deq) begin
        r_head <= r_head + c_PTR_ONE;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (core_we && buf_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Scan oldest to youngest so the last match wins; word-granular compare.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + c_PTR_W'(i);
      if ((c_CNT_W'(i) < r_count) && (r_addr[w_idx][31:2] == core_addr[31:2])) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_idx];
      end
    end
  end

  assign core_rdata = (!core_we && w_fwd_hit) ? w_fwd_data : mem_rdata;

endmodule
`default_nettype wire
